// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one SDRAM controller port between NUM_MASTERS requesters.
// One transaction per grant; return strobes are decoded from controller IDs (index+1).
module sdram_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_MASTERS-1:0]    m_request,
  input  logic [NUM_MASTERS-1:0]    m_write,
  input  logic [NUM_MASTERS-1:0]    m_burst,
  input  logic [NUM_MASTERS*26-1:0] m_address,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  input  logic [NUM_MASTERS*4-1:0]  m_byte_en,
  output logic [31:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]    m_valid,
  output logic [NUM_MASTERS-1:0]    m_complete,
  output logic                      timeout_error,
  output logic                      sdram_request,
  output logic [3:0]                sdram_master,
  output logic                      sdram_write,
  output logic                      sdram_burst,
  output logic [25:0]               sdram_address,
  output logic [31:0]               sdram_wdata,
  output logic [3:0]                sdram_byte_en,
  input  logic [31:0]               sdram_rdata,
  input  logic [3:0]                sdram_valid,
  input  logic [3:0]                sdram_complete
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [4:0] N5   = 5'(NUM_MASTERS);
  localparam logic [7:0] TO8  = 8'(TIMEOUT);

  logic [1:0] state_reg;
  logic [3:0] grant_reg;
  logic [3:0] rr_ptr_reg;
  logic [7:0] watchdog_reg;
  logic       timeout_error_reg;
  logic       sdram_request_reg;
  logic [3:0] sdram_master_reg;

  logic [NUM_MASTERS-1:0] rotated;
  logic                   hit;
  logic [3:0]             hit_idx;
  logic [3:0]             rr_after;
  logic                   grant_valid;
  logic                   own_complete;
  logic                   wd_fire;

  logic [25:0] addr_arr [NUM_MASTERS];
  logic [31:0] wdata_arr [NUM_MASTERS];
  logic [3:0]  be_arr [NUM_MASTERS];

  // Rotate requests so bit 0 is the master at the rr pointer; lowest set bit wins.
  assign rotated = (m_request >> rr_ptr_reg) | (m_request << (N5 - {1'b0, rr_ptr_reg}));

  always_comb begin
    logic [3:0] off;
    logic [4:0] sum;
    hit = 1'b0;
    off = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        hit = 1'b1;
        off = 4'(k);
      end
    end
    sum = {1'b0, rr_ptr_reg} + {1'b0, off};
    if (sum >= N5) sum = sum - N5;
    hit_idx = sum[3:0];
  end

  always_comb begin
    logic [4:0] nxt;
    nxt = {1'b0, grant_reg} + 5'd1;
    if (nxt >= N5) nxt = 5'd0;
    rr_after = nxt[3:0];
  end

  assign grant_valid  = (state_reg != IDLE);
  assign own_complete = (sdram_complete == grant_reg + 4'd1);
  assign wd_fire      = (state_reg == BUSY) && (watchdog_reg == TO8) && !own_complete;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      grant_reg         <= '0;
      rr_ptr_reg        <= '0;
      watchdog_reg      <= '0;
      timeout_error_reg <= 1'b0;
      sdram_request_reg <= 1'b0;
      sdram_master_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit) begin
            grant_reg         <= hit_idx;
            sdram_request_reg <= 1'b1;
            sdram_master_reg  <= hit_idx + 4'd1;
            watchdog_reg      <= '0;
            state_reg         <= BUSY;
          end
        end
        BUSY: begin
          watchdog_reg <= watchdog_reg + 8'd1;
          if (own_complete) begin
            sdram_request_reg <= 1'b0;
            rr_ptr_reg        <= rr_after;
            state_reg         <= GAP;
          end else if (wd_fire) begin
            sdram_request_reg <= 1'b0;
            timeout_error_reg <= 1'b1;
            rr_ptr_reg        <= rr_after;
            state_reg         <= GAP;
          end
        end
        GAP: begin
          sdram_master_reg <= '0;
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign addr_arr[gi]   = m_address[26*gi +: 26];
    assign wdata_arr[gi]  = m_wdata[32*gi +: 32];
    assign be_arr[gi]     = m_byte_en[4*gi +: 4];
    // Decoded from controller IDs only, so late read words still reach their owner.
    assign m_valid[gi]    = !reset && (sdram_valid == 4'(gi + 1));
    assign m_complete[gi] = !reset && ((sdram_complete == 4'(gi + 1)) ||
                                       (wd_fire && (grant_reg == 4'(gi))));
  end

  // Command fields stay driven through GAP so the controller sees stable values.
  always_comb begin
    sdram_write   = 1'b0;
    sdram_burst   = 1'b0;
    sdram_address = '0;
    sdram_wdata   = '0;
    sdram_byte_en = '0;
    if (grant_valid) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_reg == 4'(k)) begin
          sdram_write   = m_write[k];
          sdram_burst   = m_burst[k];
          sdram_address = addr_arr[k];
          sdram_wdata   = wdata_arr[k];
          sdram_byte_en = be_arr[k];
        end
      end
    end
  end

  assign m_rdata       = sdram_rdata;
  assign timeout_error = timeout_error_reg;
  assign sdram_request = sdram_request_reg;
  assign sdram_master  = sdram_master_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for sdram_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_arbiter;
  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  m_request = '0, m_write = '0, m_burst = '0;
  logic [N*26-1:0] m_address = '0;
  logic [N*32-1:0] m_wdata = '0;
  logic [N*4-1:0]  m_byte_en = '0;
  logic [31:0]   m_rdata;
  logic [N-1:0]  m_valid, m_complete;
  logic          timeout_error, sdram_request, sdram_write, sdram_burst;
  logic [3:0]    sdram_master, sdram_byte_en;
  logic [25:0]   sdram_address;
  logic [31:0]   sdram_wdata;
  logic [31:0]   sdram_rdata;
  logic [3:0]    sdram_valid, sdram_complete;

  logic          hang = 1'b0;
  logic [3:0]    inj_valid = '0, inj_complete = '0;
  logic [31:0]   mem [256];

  int n_checks = 0, n_fail = 0;
  int vcnt [N];
  int multi_err = 0;
  int grant_log [$];
  logic prev_req = 1'b0;

  always #5 clock = ~clock;

  sdram_arbiter #(.NUM_MASTERS(N), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .m_request(m_request), .m_write(m_write), .m_burst(m_burst),
    .m_address(m_address), .m_wdata(m_wdata), .m_byte_en(m_byte_en),
    .m_rdata(m_rdata), .m_valid(m_valid), .m_complete(m_complete),
    .timeout_error(timeout_error),
    .sdram_request(sdram_request), .sdram_master(sdram_master),
    .sdram_write(sdram_write), .sdram_burst(sdram_burst),
    .sdram_address(sdram_address), .sdram_wdata(sdram_wdata), .sdram_byte_en(sdram_byte_en),
    .sdram_rdata(sdram_rdata), .sdram_valid(sdram_valid), .sdram_complete(sdram_complete)
  );

  // Controller model: read words at accept+2.., complete one cycle before the last word.
  initial begin : ctrl_model
    int mstate, cnt, nwords;
    logic [3:0] cid;
    logic cwr;
    logic [7:0] cidx;
    mstate = 0; cnt = 0; nwords = 1; cid = '0; cwr = 1'b0; cidx = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    sdram_valid = '0; sdram_complete = '0; sdram_rdata = '0;
    forever begin
      @(posedge clock); #1;
      sdram_valid = '0; sdram_complete = '0;
      if (reset) mstate = 0;
      else begin
        case (mstate)
          0: if (sdram_request) begin
               if (hang) mstate = 3;
               else begin
                 cid = sdram_master; cwr = sdram_write; nwords = sdram_burst ? 8 : 1;
                 cidx = sdram_address[9:2]; cnt = 0; mstate = 1;
               end
             end
          1: begin
               cnt++;
               if (cwr) begin
                 if (cnt == 2) begin
                   for (int b = 0; b < 4; b++)
                     if (sdram_byte_en[b]) mem[cidx][8*b +: 8] = sdram_wdata[8*b +: 8];
                   sdram_complete = cid; mstate = 2;
                 end
               end else begin
                 if (cnt >= 2) begin sdram_valid = cid; sdram_rdata = mem[8'(cidx + cnt - 2)]; end
                 if (cnt == nwords) sdram_complete = cid;
                 if (cnt == nwords + 1) mstate = 2;
               end
             end
          2, 3: if (!sdram_request) mstate = 0;
          default: mstate = 0;
        endcase
      end
      if (inj_valid != 0) sdram_valid = inj_valid;
      if (inj_complete != 0) sdram_complete = inj_complete;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clock);
      for (int k = 0; k < N; k++) if (m_valid[k]) vcnt[k]++;
      if ((m_valid & (m_valid - 1'b1)) != 0) multi_err++;
      if (sdram_request && !prev_req) grant_log.push_back(int'(sdram_master));
      prev_req = sdram_request;
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic set_master(input int i, input logic w, input logic b, input logic [25:0] a,
                            input logic [31:0] d, input logic [3:0] be);
    m_write[i] = w; m_burst[i] = b; m_address[26*i +: 26] = a;
    m_wdata[32*i +: 32] = d; m_byte_en[4*i +: 4] = be;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1; m_request = '0; inj_valid = '0; inj_complete = '0; hang = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_complete(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (m_complete[i]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0) begin n_fail++; $display("FAIL reset_request act=%0b req=0", sdram_request); end
    n_checks++; if (sdram_master !== 4'd0) begin n_fail++; $display("FAIL reset_master act=%0h req=0", sdram_master); end
    n_checks++; if (m_valid !== 4'd0 || m_complete !== 4'd0) begin n_fail++; $display("FAIL reset_strobes act=%b/%b req=0000/0000", m_valid, m_complete); end
    n_checks++; if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_error act=%0b req=0", timeout_error); end
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || sdram_address !== 26'd0 || sdram_write !== 1'b0) begin n_fail++; $display("FAIL idle_mux act=%0b/%0h/%0b req=0/0/0", sdram_request, sdram_address, sdram_write); end
    $display("txn reset done");
  endtask

  task automatic test_single_read();
    int v0 [N];
    bit ok;
    v0 = vcnt;
    set_master(1, 1'b0, 1'b0, 26'h0001000, 32'h0, 4'hF);
    m_request[1] = 1'b1;
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b1 || sdram_master !== 4'd2) begin n_fail++; $display("FAIL single_grant act=%0b/%0h req=1/2", sdram_request, sdram_master); end
    n_checks++; if (sdram_address !== 26'h0001000 || sdram_burst !== 1'b0) begin n_fail++; $display("FAIL single_cmd act=%0h/%0b req=1000/0", sdram_address, sdram_burst); end
    wait_complete(1, ok);
    m_request[1] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_complete act=none req=m_complete[1]"); end
    n_checks++; if (m_valid !== 4'd0) begin n_fail++; $display("FAIL single_valid_early act=%b req=0000", m_valid); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || sdram_master !== 4'd2) begin n_fail++; $display("FAIL single_gap act=%0b/%0h req=0/2", sdram_request, sdram_master); end
    n_checks++; if (m_valid !== 4'b0010 || m_rdata !== 32'hA500_0000) begin n_fail++; $display("FAIL single_data act=%b/%h req=0010/a5000000", m_valid, m_rdata); end
    @(negedge clock);
    n_checks++; if (sdram_master !== 4'd0) begin n_fail++; $display("FAIL single_idle act=%0h req=0", sdram_master); end
    n_checks++; if (vcnt[1] - v0[1] != 1 || vcnt[0] != v0[0] || vcnt[2] != v0[2] || vcnt[3] != v0[3]) begin n_fail++; $display("FAIL single_valid_count act=%0d req=1", vcnt[1] - v0[1]); end
    $display("txn single_read master=1 addr=0001000");
  endtask

  task automatic test_round_robin();
    int v0 [N];
    int g0, m0;
    int exp_g [5];
    int exp_v [N];
    bit ok;
    exp_g = '{1, 2, 3, 4, 1};
    exp_v = '{16, 8, 8, 8};
    apply_reset();
    v0 = vcnt; g0 = grant_log.size(); m0 = multi_err;
    for (int i = 0; i < N; i++) set_master(i, 1'b0, 1'b1, 26'(32'h100 * (i + 1)), 32'h0, 4'hF);
    m_request = 4'hF;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (grant_log.size() >= g0 + 5) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_five_grants act=%0d req=5", grant_log.size() - g0); end
    m_request[3:1] = 3'b000;
    wait_complete(0, ok);
    m_request[0] = 1'b0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_final_complete act=none req=m_complete[0]"); end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (grant_log.size() <= g0 + k || grant_log[g0 + k] != exp_g[k]) begin
        n_fail++; $display("FAIL rr_order_%0d act=%0d req=%0d", k, (grant_log.size() > g0 + k) ? grant_log[g0 + k] : -1, exp_g[k]);
      end
    end
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (vcnt[k] - v0[k] != exp_v[k]) begin n_fail++; $display("FAIL rr_burst_valids_m%0d act=%0d req=%0d", k, vcnt[k] - v0[k], exp_v[k]); end
    end
    n_checks++; if (multi_err != m0) begin n_fail++; $display("FAIL rr_onehot act=%0d req=0", multi_err - m0); end
    $display("txn round_robin grants=%0d", grant_log.size() - g0);
  endtask

  task automatic test_write();
    bit ok;
    set_master(2, 1'b1, 1'b0, 26'h0000040, 32'hDEADBEEF, 4'hF);
    m_request[2] = 1'b1;
    @(negedge clock);
    n_checks++; if (sdram_master !== 4'd3 || sdram_write !== 1'b1 || sdram_wdata !== 32'hDEADBEEF || sdram_byte_en !== 4'hF) begin n_fail++; $display("FAIL wr_grant act=%0h/%0b/%h/%h req=3/1/deadbeef/f", sdram_master, sdram_write, sdram_wdata, sdram_byte_en); end
    wait_complete(2, ok);
    m_request[2] = 1'b0;
    n_checks++; if (!ok || sdram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_complete act=%0b/%h req=1/deadbeef", ok, sdram_wdata); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || sdram_wdata !== 32'hDEADBEEF || sdram_address !== 26'h40 || sdram_write !== 1'b1) begin n_fail++; $display("FAIL wr_gap_stable act=%0b/%h/%h/%0b req=0/deadbeef/40/1", sdram_request, sdram_wdata, sdram_address, sdram_write); end
    @(negedge clock);
    n_checks++; if (sdram_wdata !== 32'd0 || sdram_write !== 1'b0) begin n_fail++; $display("FAIL wr_idle_mux act=%h/%0b req=0/0", sdram_wdata, sdram_write); end
    n_checks++; if (mem[16] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_memory act=%h req=deadbeef", mem[16]); end
    $display("txn write master=2 data=deadbeef");
  endtask

  task automatic test_back_to_back();
    int v0 [N];
    bit ok;
    apply_reset();
    set_master(0, 1'b0, 1'b0, 26'h0000010, 32'h0, 4'hF);
    set_master(3, 1'b0, 1'b0, 26'h0000020, 32'h0, 4'hF);
    v0 = vcnt;
    m_request = 4'b1001;
    @(negedge clock);
    n_checks++; if (sdram_master !== 4'd1) begin n_fail++; $display("FAIL b2b_first act=%0h req=1", sdram_master); end
    wait_complete(0, ok);
    m_request[0] = 1'b0;
    n_checks++; if (!ok || m_valid !== 4'd0) begin n_fail++; $display("FAIL b2b_complete act=%0b/%b req=1/0000", ok, m_valid); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || m_valid !== 4'b0001 || m_rdata !== 32'hA500_0004) begin n_fail++; $display("FAIL b2b_gap_word act=%0b/%b/%h req=0/0001/a5000004", sdram_request, m_valid, m_rdata); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || sdram_master !== 4'd0 || m_valid !== 4'd0) begin n_fail++; $display("FAIL b2b_idle act=%0b/%0h/%b req=0/0/0000", sdram_request, sdram_master, m_valid); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b1 || sdram_master !== 4'd4) begin n_fail++; $display("FAIL b2b_next_grant act=%0b/%0h req=1/4", sdram_request, sdram_master); end
    wait_complete(3, ok);
    m_request[3] = 1'b0;
    @(negedge clock);
    n_checks++; if (!ok || m_valid !== 4'b1000 || m_rdata !== 32'hA500_0008) begin n_fail++; $display("FAIL b2b_second_data act=%0b/%b/%h req=1/1000/a5000008", ok, m_valid, m_rdata); end
    n_checks++; if (vcnt[0] - v0[0] != 1 || vcnt[3] - v0[3] != 1) begin n_fail++; $display("FAIL b2b_counts act=%0d/%0d req=1/1", vcnt[0] - v0[0], vcnt[3] - v0[3]); end
    @(negedge clock);
    $display("txn back_to_back masters=0,3");
  endtask

  task automatic test_id_decode();
    inj_valid = 4'd5; inj_complete = 4'd15;
    @(negedge clock);
    n_checks++; if (m_valid !== 4'd0 || m_complete !== 4'd0) begin n_fail++; $display("FAIL id_out_of_range act=%b/%b req=0000/0000", m_valid, m_complete); end
    inj_valid = 4'd3; inj_complete = 4'd1;
    @(negedge clock);
    n_checks++; if (m_valid !== 4'b0100 || m_complete !== 4'b0001) begin n_fail++; $display("FAIL id_decode act=%b/%b req=0100/0001", m_valid, m_complete); end
    inj_valid = '0; inj_complete = '0;
    repeat (2) @(negedge clock);
    $display("txn id_decode");
  endtask

  task automatic test_timeout();
    int fire_c;
    bit ok;
    apply_reset();
    hang = 1'b1;
    set_master(0, 1'b0, 1'b0, 26'h0000000, 32'h0, 4'hF);
    set_master(1, 1'b0, 1'b0, 26'h0000004, 32'h0, 4'hF);
    m_request = 4'b0011;
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b1 || sdram_master !== 4'd1) begin n_fail++; $display("FAIL to_grant act=%0b/%0h req=1/1", sdram_request, sdram_master); end
    fire_c = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (c == 3) inj_complete = 4'd4;
      if (c == 4) begin
        n_checks++; if (m_complete !== 4'b1000) begin n_fail++; $display("FAIL to_foreign_complete act=%b req=1000", m_complete); end
        inj_complete = '0;
      end
      if (c == 5) begin
        n_checks++; if (sdram_request !== 1'b1 || sdram_master !== 4'd1) begin n_fail++; $display("FAIL to_still_busy act=%0b/%0h req=1/1", sdram_request, sdram_master); end
      end
      if (m_complete[0]) begin fire_c = c; break; end
    end
    n_checks++; if (fire_c != 16 || m_complete !== 4'b0001) begin n_fail++; $display("FAIL to_fire_cycle act=%0d/%b req=16/0001", fire_c, m_complete); end
    m_request[0] = 1'b0;
    hang = 1'b0;
    @(negedge clock);
    n_checks++; if (timeout_error !== 1'b1 || sdram_request !== 1'b0) begin n_fail++; $display("FAIL to_error_flag act=%0b/%0b req=1/0", timeout_error, sdram_request); end
    wait_complete(1, ok);
    m_request[1] = 1'b0;
    n_checks++; if (!ok || grant_log[grant_log.size() - 1] != 2) begin n_fail++; $display("FAIL to_next_master act=%0b/%0d req=1/2", ok, grant_log[grant_log.size() - 1]); end
    @(negedge clock);
    n_checks++; if (timeout_error !== 1'b1 || m_valid !== 4'b0010 || m_rdata !== 32'hA500_0001) begin n_fail++; $display("FAIL to_sticky act=%0b/%b/%h req=1/0010/a5000001", timeout_error, m_valid, m_rdata); end
    @(negedge clock);
    $display("txn timeout master=0 fired_at=%0d", fire_c);
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    apply_reset();
    n_checks++; if (timeout_error !== 1'b0) begin n_fail++; $display("FAIL mid_error_cleared act=%0b req=0", timeout_error); end
    set_master(1, 1'b0, 1'b1, 26'h0000080, 32'h0, 4'hF);
    m_request[1] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (m_valid[1]) begin ok = 1'b1; break; end
    end
    @(negedge clock);
    n_checks++; if (!ok || m_valid !== 4'b0010) begin n_fail++; $display("FAIL mid_burst_active act=%0b/%b req=1/0010", ok, m_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (m_valid !== 4'd0 || m_complete !== 4'd0) begin n_fail++; $display("FAIL mid_forced_zero act=%b/%b req=0000/0000", m_valid, m_complete); end
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0 || sdram_master !== 4'd0 || sdram_address !== 26'd0) begin n_fail++; $display("FAIL mid_reset_state act=%0b/%0h/%h req=0/0/0", sdram_request, sdram_master, sdram_address); end
    n_checks++; if (m_valid !== 4'd0 || m_complete !== 4'd0) begin n_fail++; $display("FAIL mid_strobes act=%b/%b req=0000/0000", m_valid, m_complete); end
    m_request = '0;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (sdram_request !== 1'b0) begin n_fail++; $display("FAIL mid_no_regrant act=%0b req=0", sdram_request); end
    $display("txn reset_mid_burst master=1");
  endtask

  initial begin : main
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_back_to_back();
    test_id_decode();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
